truth_table_sweeper: RTL



---
 rtl/truth_table_sweeper_pkg.sv | 15 +
 rtl/truth_table_sweeper_settle_timer.sv | 39 +++
 rtl/truth_table_sweeper.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and sizing for the truth-table sweep engine.
package truth_table_sweeper_pkg;

    localparam int unsigned MINTERMS = 16;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned CNT_W    = 5;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StSample,
        StDone
    } state_e;

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Settle down-counter: loaded with SETTLE as the FSM enters WAIT, then counts
// down while enabled. zero marks the final WAIT cycle, where the count reaches
// zero at the closing edge.
module truth_table_sweeper_settle_timer
    import truth_table_sweeper_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero
);

    logic [IDX_W-1:0] cnt_q, cnt_d;

    // Load on WAIT entry, otherwise count down while WAIT is active.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = IDX_W'(SETTLE);
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - IDX_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = en && (cnt_q <= IDX_W'(1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all 16 minterms onto {x,y,w,z}, captures two function outputs into
// truth tables and reports mismatch count, first mismatch and equivalence.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                x,
    output logic                y,
    output logic                w,
    output logic                z,
    input  logic                s1,
    input  logic                s2,
    output logic                busy,
    output logic                done,
    output logic [MINTERMS-1:0] tt1,
    output logic [MINTERMS-1:0] tt2,
    output logic [CNT_W-1:0]    mism_cnt,
    output logic [IDX_W-1:0]    first_mism,
    output logic                equal
);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    vec_q, vec_d;
    logic [MINTERMS-1:0] tt1_q, tt1_d;
    logic [MINTERMS-1:0] tt2_q, tt2_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    first_q, first_d;
    logic                equal_q, equal_d;
    logic                timer_load;
    logic                timer_zero;

    truth_table_sweeper_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .en    (state_q == StWait),
        .zero  (timer_zero)
    );

    // Next-state, index stepping and result accumulation.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tt1_d      = tt1_q;
        tt2_d      = tt2_q;
        cnt_d      = cnt_q;
        first_d    = first_q;
        equal_d    = equal_q;
        timer_load = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    tt1_d   = '0;
                    tt2_d   = '0;
                    cnt_d   = '0;
                    first_d = '0;
                    equal_d = 1'b0;
                    idx_d   = '0;
                    if (SETTLE > 0) begin
                        state_d    = StWait;
                        timer_load = 1'b1;
                    end else begin
                        state_d = StSample;
                    end
                end
            end
            StWait: begin
                if (timer_zero) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                tt1_d[idx_q] = s1;
                tt2_d[idx_q] = s2;
                if (s1 != s2) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // Count still zero means this is the first mismatch.
                    if (cnt_q == '0) begin
                        first_d = idx_q;
                    end
                end
                if (idx_q == IDX_W'(MINTERMS - 1)) begin
                    state_d = StDone;
                    // Includes the final sample so equal is valid in the DONE cycle.
                    equal_d = (cnt_d == '0);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    if (SETTLE > 0) begin
                        state_d    = StWait;
                        timer_load = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Minterm output register follows the index only while sweeping.
    always_comb begin
        vec_d = '0;
        if ((state_d == StWait) || (state_d == StSample)) begin
            vec_d = idx_d;
        end
    end

    // State, index and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            vec_q   <= '0;
            tt1_q   <= '0;
            tt2_q   <= '0;
            cnt_q   <= '0;
            first_q <= '0;
            equal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            tt1_q   <= tt1_d;
            tt2_q   <= tt2_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            equal_q <= equal_d;
        end
    end

    assign {x, y, w, z} = vec_q;
    assign busy         = (state_q == StWait) || (state_q == StSample);
    assign done         = (state_q == StDone);
    assign tt1          = tt1_q;
    assign tt2          = tt2_q;
    assign mism_cnt     = cnt_q;
    assign first_mism   = first_q;
    assign equal        = equal_q;

endmodule
